// File: rtl/mag_comparator.sv
// Registered magnitude comparator: o = 01 (a>b), 10 (a<b), 00 (a==b), one cycle after in_valid.
// Define MAG_CASCADE_EN to add gt_in/lt_in cascade inputs that resolve the a==b case (7485 style).
module mag_comparator #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MAG_CASCADE_EN
  input  logic             gt_in,
  input  logic             lt_in,
`endif
  output logic [1:0]       o,
  output logic             out_valid
);

  logic       gt;
  logic       lt;
  logic       decided;
  logic [1:0] code;

  // MSB-first scan; the first differing bit decides. In signed mode a set MSB marks the smaller operand.
  always_comb begin
    gt      = 1'b0;
    lt      = 1'b0;
    decided = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        decided = 1'b1;
        if (SIGNED && (i == WIDTH - 1)) begin
          gt = b[i];
          lt = a[i];
        end else begin
          gt = a[i];
          lt = b[i];
        end
      end
    end
    code = {lt, gt};
`ifdef MAG_CASCADE_EN
    if (!decided) begin
      code = (gt_in && lt_in) ? 2'b00 : {lt_in, gt_in};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o         <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o <= code;
      end
    end
  end

endmodule

// File: tb/tb_mag_comparator.sv
// Directed bench for mag_comparator: unsigned/signed width-4 and width-1 instances.
module tb_mag_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4, b4;
  logic [0:0] a1, b1;
  logic       gt_in, lt_in;
  logic [1:0] o_u, o_s, o_1;
  logic       v_u, v_s, v_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mag_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
`ifdef MAG_CASCADE_EN
    .gt_in(gt_in), .lt_in(lt_in),
`endif
    .o(o_u), .out_valid(v_u));

  mag_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
`ifdef MAG_CASCADE_EN
    .gt_in(gt_in), .lt_in(lt_in),
`endif
    .o(o_s), .out_valid(v_s));

  mag_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
`ifdef MAG_CASCADE_EN
    .gt_in(gt_in), .lt_in(lt_in),
`endif
    .o(o_1), .out_valid(v_1));

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_cmp(input int x, input int y);
    if (x > y) return 2'b01;
    if (x < y) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int to_s4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b1; a4 = 4'hA; b4 = 4'h3; a1 = 1'b1; b1 = 1'b0;
    gt_in = 1'b0; lt_in = 1'b0;
    #1;

    // reset for two cycles with live operands
    tick();
    tick();
    check("rst_o", o_u, 2'b00);
    check("rst_v", {1'b0, v_u}, 2'b00);
    check("rst_o_s", o_s, 2'b00);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_v", {1'b0, v_u}, 2'b00);
    check("idle_o", o_u, 2'b00);

    // back-to-back pairs
    in_valid = 1'b1; a4 = 4'd1; b4 = 4'd1;
    tick();
    check("b2b_eq", o_u, 2'b00);
    check("b2b_eq_v", {1'b0, v_u}, 2'b01);
    a4 = 4'd1; b4 = 4'd0;
    tick();
    check("b2b_gt", o_u, 2'b01);
    check("b2b_gt_v", {1'b0, v_u}, 2'b01);
    a4 = 4'd0; b4 = 4'd1;
    tick();
    check("b2b_lt", o_u, 2'b10);
    check("b2b_lt_v", {1'b0, v_u}, 2'b01);

    // exhaustive sweep, unsigned and signed instances in parallel
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j);
        tick();
        check($sformatf("sweep_u_%0d_%0d", i, j), o_u, ref_cmp(i, j));
        check($sformatf("sweep_s_%0d_%0d", i, j), o_s, ref_cmp(to_s4(i), to_s4(j)));
      end
    end
    check("sweep_v", {1'b0, v_u}, 2'b01);

    // hold when in_valid drops: last pair was F,F -> 00; use a GT pair first
    a4 = 4'hF; b4 = 4'h0;
    tick();
    check("bnd_u_f0", o_u, 2'b01);
    in_valid = 1'b0; a4 = 4'h0; b4 = 4'hF;
    tick();
    check("hold_o", o_u, 2'b01);
    check("hold_v", {1'b0, v_u}, 2'b00);
    in_valid = 1'b1;

    // signed directed and boundaries
    a4 = 4'h8; b4 = 4'h7;
    tick();
    check("s_8_7", o_s, 2'b10);
    check("u_8_7", o_u, 2'b01);
    a4 = 4'hF; b4 = 4'hE;
    tick();
    check("s_f_e", o_s, 2'b01);
    a4 = 4'h0; b4 = 4'hF;
    tick();
    check("s_0_f", o_s, 2'b01);
    check("u_0_f", o_u, 2'b10);
    a4 = 4'h0; b4 = 4'h0;
    tick();
    check("eq_0", o_u, 2'b00);
    a4 = 4'hF; b4 = 4'hF;
    tick();
    check("eq_f", o_u, 2'b00);
    check("eq_f_s", o_s, 2'b00);

    // width 1
    a1 = 1'b1; b1 = 1'b0;
    tick();
    check("w1_gt", o_1, 2'b01);
    a1 = 1'b0; b1 = 1'b1;
    tick();
    check("w1_lt", o_1, 2'b10);
    a1 = 1'b1; b1 = 1'b1;
    tick();
    check("w1_eq", o_1, 2'b00);
    a1 = 1'b0; b1 = 1'b0;

    // reset wins over in_valid
    a4 = 4'd5; b4 = 4'd3;
    tick();
    check("pre_rst", o_u, 2'b01);
    rst = 1'b1;
    tick();
    check("rst_pri_o", o_u, 2'b00);
    check("rst_pri_v", {1'b0, v_u}, 2'b00);
    rst = 1'b0;

`ifdef MAG_CASCADE_EN
    a4 = 4'd9; b4 = 4'd9; gt_in = 1'b1; lt_in = 1'b0;
    tick();
    check("cas_gt", o_u, 2'b01);
    gt_in = 1'b0; lt_in = 1'b1;
    tick();
    check("cas_lt", o_u, 2'b10);
    gt_in = 1'b1; lt_in = 1'b1;
    tick();
    check("cas_both", o_u, 2'b00);
    a4 = 4'd3; b4 = 4'd9; gt_in = 1'b1; lt_in = 1'b0;
    tick();
    check("cas_ignored", o_u, 2'b10);
    gt_in = 1'b0;
`endif

    in_valid = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
